// File: rtl/regfile_uart_dump.sv
// Walks the register file debug port and streams "xNN=HHHHHHHH\r\n" lines out an 8N1 UART.
// Optional `REGDUMP_HEADER_EN prepends a "REGS\r\n" banner before x00.
module regfile_uart_dump #(
  parameter int CLKS_PER_BIT = 868,
  parameter int NUM_REGS     = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [4:0]  dbg_raddr,
  input  logic [31:0] dbg_rdata,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_CAPTURE, S_LOAD, S_SEND, S_DONE} state_t;

  state_t        state;
  logic [4:0]    reg_idx;
  logic [3:0]    char_idx;
  logic [31:0]   line_buf;
  logic [8:0]    shreg;
  logic [3:0]    bit_idx;
  logic [TW-1:0] bit_tmr;
  logic [7:0]    ch;
  logic [1:0]    tens;
  logic [3:0]    ones;
`ifdef REGDUMP_HEADER_EN
  logic          hdr_active;
  logic [2:0]    hdr_idx;

  function automatic logic [7:0] hdr_rom(input logic [2:0] a);
    case (a)
      3'd0:    return 8'h52;
      3'd1:    return 8'h45;
      3'd2:    return 8'h47;
      3'd3:    return 8'h53;
      3'd4:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction
`endif

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction

  // Index is at most 31, so a threshold ladder replaces a divider.
  always_comb begin
    tens = 2'd0;
    ones = reg_idx[3:0];
    if (reg_idx >= 5'd30) begin
      tens = 2'd3; ones = 4'(reg_idx - 5'd30);
    end else if (reg_idx >= 5'd20) begin
      tens = 2'd2; ones = 4'(reg_idx - 5'd20);
    end else if (reg_idx >= 5'd10) begin
      tens = 2'd1; ones = 4'(reg_idx - 5'd10);
    end
  end

  // Hex digits always come from the top nibble; line_buf shifts left as each is sent.
  always_comb begin
    case (char_idx)
      4'd0:    ch = 8'h78;
      4'd1:    ch = 8'h30 + {6'd0, tens};
      4'd2:    ch = 8'h30 + {4'd0, ones};
      4'd3:    ch = 8'h3D;
      4'd12:   ch = 8'h0D;
      4'd13:   ch = 8'h0A;
      default: ch = hex_ascii(line_buf[31:28]);
    endcase
`ifdef REGDUMP_HEADER_EN
    if (hdr_active) ch = hdr_rom(hdr_idx);
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      reg_idx   <= '0;
      char_idx  <= '0;
      line_buf  <= '0;
      shreg     <= '1;
      bit_idx   <= '0;
      bit_tmr   <= '0;
      dbg_raddr <= '0;
      uart_tx   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REGDUMP_HEADER_EN
      hdr_active <= 1'b0;
      hdr_idx    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (start) begin
          busy    <= 1'b1;
          reg_idx <= '0;
          state   <= S_ADDR;
`ifdef REGDUMP_HEADER_EN
          hdr_active <= 1'b1;
          hdr_idx    <= '0;
`endif
        end
        S_ADDR: begin
          dbg_raddr <= reg_idx;
          state     <= S_CAPTURE;
        end
        S_CAPTURE: begin
          line_buf <= dbg_rdata;
          char_idx <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          shreg   <= {1'b1, ch};
          uart_tx <= 1'b0;
          bit_idx <= '0;
          bit_tmr <= '0;
          if (char_idx >= 4'd4 && char_idx <= 4'd11) line_buf <= {line_buf[27:0], 4'h0};
          state   <= S_SEND;
        end
        S_SEND: begin
          if (bit_tmr == TW'(CLKS_PER_BIT - 1)) begin
            bit_tmr <= '0;
            if (bit_idx == 4'd9) begin
`ifdef REGDUMP_HEADER_EN
              if (hdr_active) begin
                if (hdr_idx == 3'd5) begin
                  hdr_active <= 1'b0;
                  state      <= S_ADDR;
                end else begin
                  hdr_idx <= hdr_idx + 3'd1;
                  state   <= S_LOAD;
                end
              end else
`endif
              if (char_idx != 4'd13) begin
                char_idx <= char_idx + 4'd1;
                state    <= S_LOAD;
              end else if (reg_idx == 5'(NUM_REGS - 1)) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                reg_idx <= reg_idx + 5'd1;
                state   <= S_ADDR;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              uart_tx <= shreg[0];
              shreg   <= {1'b1, shreg[8:1]};
            end
          end else begin
            bit_tmr <= bit_tmr + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/regfile_uart_dump.md
# regfile_uart_dump

Debug stage downstream of `pipelined_datapath`. On a start pulse, walks the 32-entry register file through a debug read port and formats each entry as an ASCII line. Sends the lines over a UART transmitter (8N1), giving a register dump on real hardware without a simulator. It sits beside the board-level `btn`/`sw`/`reg_out` debug path and consumes the register file's debug read port.

## Interface
- `CLKS_PER_BIT`, 868 — clk cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
- `NUM_REGS`, 32 — registers dumped, indices 0..NUM_REGS-1; legal range 1..32.
- `clk  in  1` — system clock, rising edge.
- `resetn  in  1` — asynchronous, active-low reset.
- `start  in  1` — single-cycle dump request (already debounced/edge-detected upstream).
- `dbg_raddr  out  5` — register index driven to the register file debug read port.
- `dbg_rdata  in  32` — register file debug read data; combinational from `dbg_raddr`.
- `uart_tx  out  1` — serial output; idle high.
- `busy  out  1` — high from acceptance of `start` until the dump completes.
- `done  out  1` — one-cycle pulse when the last stop bit completes.

## Operation
- Line format per register i: `x`, two decimal digits of i, `=`, eight uppercase hex digits MSB-first, CR (0x0D), LF (0x0A). Each line is 14 bytes.
- FSM states:
  - IDLE: `busy`=0; on `start` → ADDR.
  - ADDR: drive `dbg_raddr`=i → CAPTURE.
  - CAPTURE: latch `dbg_rdata` into a 32-bit line buffer; char index=0 → LOAD.
  - LOAD: select the character and hand it to the TX shifter → SEND.
  - SEND: wait for the TX shifter to finish.
    - Next char in the line → LOAD.
    - End of line with i < NUM_REGS-1 → i+1, ADDR.
    - End of line with i = NUM_REGS-1 → DONE.
  - DONE: pulse `done`, drop `busy` → IDLE.
- TX shifter:
  - Frame is start bit (0), 8 data bits LSB-first, stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles, counted by a bit-timer.
  - Bit index counts 0..9.
- Each register value is snapshotted when it is captured. The dump is not an atomic snapshot of the whole file; a register written during the dump shows its value at its own CAPTURE cycle.
- Decimal index: tens digit = i/10, ones digit = i%10. Both come from a small constant lookup, not a divider.
- Hex nibble n maps to 0x30+n for n < 10 and 0x37+n for n ≥ 10.

## Timing
- Reset values (asynchronous, immediate): `uart_tx`=1, `busy`=0, `done`=0, `dbg_raddr`=0, FSM=IDLE, all counters 0.
- `start` sampled high in IDLE: `busy`=1 from the next rising edge.
- The first start bit (`uart_tx`=0) begins 3 cycles after `start`: one cycle each for ADDR, CAPTURE and LOAD.
- Byte length is exactly 10×CLKS_PER_BIT cycles.
- Within a line, the next start bit begins exactly 1 cycle after the previous stop bit ends (the LOAD cycle).
- Between lines, the gap is 3 idle-high cycles (ADDR, CAPTURE, LOAD).
- `done` is high for exactly 1 cycle, the cycle after the final stop bit ends. `busy` falls on that same edge.
- `start` while `busy`=1 is ignored and not queued.
- `start` in the same cycle `done` is asserted is ignored. A new dump needs `start` in IDLE.
- `resetn` low mid-byte aborts the dump, with `uart_tx` forced high at once. After release, the next `start` dumps again from x00.
- `dbg_raddr` holds its value between CAPTURE cycles.

## Configuration
- `REGDUMP_HEADER_EN`:
  - Defined: before x00, emit the 6-byte header `REGS` CR LF. The first start bit is still 3 cycles after `start` (header chars come from a constant ROM; ADDR/CAPTURE run after the header). Total dump is 6 + 14×NUM_REGS bytes.
  - Undefined: no header; total is 14×NUM_REGS bytes, and the header ROM and its FSM state are absent.

## Test plan
- Reset with CLKS_PER_BIT=4: during and after `resetn`=0, `uart_tx`=1, `busy`=0, `done`=0, `dbg_raddr`=0. No transitions on `uart_tx` for 100 cycles.
- Bench register model x0=0, x1=0x0000000A; pulse `start`:
  - Decoded bytes begin `x00=00000000\r\n` then `x01=0000000A\r\n` (0x78 0x30 0x31 0x3D …).
  - First `uart_tx` fall occurs 3 cycles after `start`.
- x31=0xDEADBEEF: line 32 decodes to `x31=DEADBEEF\r\n` with uppercase hex. x10 decodes `x10=`.
- Full dump, header disabled:
  - Exactly 448 bytes, each 40 cycles wide.
  - `done` pulses once and `busy` falls on the same edge.
  - With `REGDUMP_HEADER_EN`: 454 bytes, the first six being `REGS\r\n`.
- Pulse `start` at byte 5 and again on the `done` cycle: byte count stays 448 and no second dump starts.
- Assert `resetn`=0 in the middle of byte 20's data bits:
  - `uart_tx` goes 1 asynchronously before the next edge and `busy`=0.
  - After release, `start` yields a dump beginning `x00=`.
